// File: rtl/lin_frame_check_if.sv
// rtl/lin_frame_check_if.sv - LIN receive symbol stream and frame-check result bundle
interface lin_frame_check_if;
    logic       frame_start;
    logic [3:0] cfg_len;
    logic       cfg_enh;
    logic       sym_valid;
    logic [9:0] sym;

    logic [5:0] pid_id;
    logic       pid_ok;
    logic       pid_err;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       frame_done;
    logic       chk_err;
    logic       frm_err;
    logic       abort;
    logic       busy;

    modport master (
        output frame_start, cfg_len, cfg_enh, sym_valid, sym,
        input  pid_id, pid_ok, pid_err, rx_byte, rx_byte_valid,
               frame_done, chk_err, frm_err, abort, busy
    );

    modport slave (
        input  frame_start, cfg_len, cfg_enh, sym_valid, sym,
        output pid_id, pid_ok, pid_err, rx_byte, rx_byte_valid,
               frame_done, chk_err, frm_err, abort, busy
    );
endinterface

// File: rtl/lin_frame_check.sv
// rtl/lin_frame_check.sv - LIN frame checker: PID parity, data capture and checksum verification
module lin_frame_check #(
    parameter int MAX_LEN      = 8,
    parameter bit DIAG_CLASSIC = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    lin_frame_check_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PID  = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] CHK  = 2'd3;
    localparam logic [3:0] MAX_LEN_C = 4'(MAX_LEN);

    logic [1:0] state;
    logic [3:0] len_q;
    logic [3:0] cnt;
    logic       enh_q;
    logic [7:0] acc;

    logic [5:0] pid_id_q;
    logic [7:0] rx_byte_q;
    logic       pid_ok_q, pid_err_q, rx_byte_valid_q;
    logic       frame_done_q, chk_err_q, frm_err_q, abort_q;

    logic [5:0] id;
    logic [7:0] din;
    logic       par_ok;
    logic       framing_ok;
    logic       diag_id;
    logic [8:0] sum;
    logic [7:0] acc_next;
    logic [3:0] cnt_next;

    assign id         = bus.sym[6:1];
    assign din        = bus.sym[8:1];
    assign par_ok     = bus.sym[8:7] == {~(id[1] ^ id[3] ^ id[4] ^ id[5]),
                                           id[0] ^ id[1] ^ id[2] ^ id[4]};
    assign framing_ok = !bus.sym[0] && bus.sym[9];
    assign diag_id    = DIAG_CLASSIC && (id == 6'h3C || id == 6'h3D);
    // Ones-complement style add: fold the carry back into the low byte
    assign sum        = {1'b0, acc} + {1'b0, din};
    assign acc_next   = sum[7:0] + {7'd0, sum[8]};
    assign cnt_next   = cnt + 4'd1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            len_q           <= 4'd0;
            cnt             <= 4'd0;
            enh_q           <= 1'b0;
            acc             <= 8'd0;
            pid_id_q        <= 6'd0;
            rx_byte_q       <= 8'd0;
            pid_ok_q        <= 1'b0;
            pid_err_q       <= 1'b0;
            rx_byte_valid_q <= 1'b0;
            frame_done_q    <= 1'b0;
            chk_err_q       <= 1'b0;
            frm_err_q       <= 1'b0;
            abort_q         <= 1'b0;
        end else begin
            pid_ok_q        <= 1'b0;
            pid_err_q       <= 1'b0;
            rx_byte_valid_q <= 1'b0;
            frame_done_q    <= 1'b0;
            chk_err_q       <= 1'b0;
            frm_err_q       <= 1'b0;
            abort_q         <= 1'b0;

            if (bus.frame_start) begin
                abort_q <= (state != IDLE);
                state   <= PID;
                len_q   <= (bus.cfg_len > MAX_LEN_C) ? MAX_LEN_C : bus.cfg_len;
                enh_q   <= bus.cfg_enh;
                cnt     <= 4'd0;
                acc     <= 8'd0;
            end else if (bus.sym_valid && state != IDLE) begin
                if (!framing_ok) begin
                    frm_err_q <= 1'b1;
                    state     <= IDLE;
                end else begin
                    case (state)
                        PID: begin
                            pid_id_q <= id;
                            acc      <= (enh_q && !diag_id) ? din : 8'd0;
                            if (!par_ok) begin
                                pid_err_q <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                pid_ok_q <= 1'b1;
                                if (len_q == 4'd0) begin
                                    frame_done_q <= 1'b1;
                                    state        <= IDLE;
                                end else begin
                                    state <= DATA;
                                end
                            end
                        end
                        DATA: begin
                            rx_byte_q       <= din;
                            rx_byte_valid_q <= 1'b1;
                            acc             <= acc_next;
                            cnt             <= cnt_next;
                            if (cnt_next == len_q)
                                state <= CHK;
                        end
                        CHK: begin
                            frame_done_q <= 1'b1;
                            chk_err_q    <= (din != ~acc);
                            state        <= IDLE;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    assign bus.pid_id        = pid_id_q;
    assign bus.pid_ok        = pid_ok_q;
    assign bus.pid_err       = pid_err_q;
    assign bus.rx_byte       = rx_byte_q;
    assign bus.rx_byte_valid = rx_byte_valid_q;
    assign bus.frame_done    = frame_done_q;
    assign bus.chk_err       = chk_err_q;
    assign bus.frm_err       = frm_err_q;
    assign bus.abort         = abort_q;
    assign bus.busy          = (state != IDLE);
endmodule

// File: doc/lin_frame_check.md
LIN_FRAME_CHECK -- requirements
Module: lin_frame_check

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, meaning the maximum number of data bytes per frame (range 1..8).
REQ-002 SHALL have parameter DIAG_CLASSIC, default 1; when 1, IDs 0x3C/0x3D always use the classic checksum.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-005 SHALL have port frame_start, input, 1, a pulse marking a break/sync detection that starts a frame.
REQ-006 SHALL have port cfg_len, input, 4, the data length, captured at frame_start.
REQ-007 SHALL have port cfg_enh, input, 1, checksum mode (1 = enhanced, 0 = classic), captured at frame_start.
REQ-008 SHALL have port sym_valid, input, 1, which qualifies sym for one cycle.
REQ-009 SHALL have port sym, input, 10, a received symbol: [0] start bit, [8:1] byte LSB-first, [9] stop bit.
REQ-010 SHALL have port pid_id, output, 6, the last received ID (sym[6:1] of the PID symbol).
REQ-011 SHALL have output pulses pid_ok and pid_err, 1 bit each, reporting the PID parity result.
REQ-012 SHALL have output rx_byte, 8 bits, plus a rx_byte_valid pulse, 1 bit, marking each accepted data byte.
REQ-013 SHALL have output pulses frame_done, chk_err, frm_err and abort, 1 bit each.
REQ-014 SHALL have output busy, 1 bit, high while the FSM is not in IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, PID, DATA and CHK.
REQ-016 SHALL enter PID from any state on frame_start.
- Latch the length: cfg_len of 0 means header-only; values above MAX_LEN clamp to MAX_LEN.
- Latch cfg_enh.
- Clear the byte counter and checksum accumulator.
REQ-017 SHALL, outside IDLE, check framing on every accepted symbol.
- Failure: sym[0]!=0 or sym[9]!=1.
- Pulse frm_err and return to IDLE; no other pulses that cycle.
REQ-018 SHALL compute parity in PID from id=sym[6:1].
- P0 = id0^id1^id2^id4; P1 = ~(id1^id3^id4^id5).
- Match is sym[8:7] == {P1,P0}.
REQ-019 SHALL, on a PID match:
- Pulse pid_ok and update pid_id.
- Go to DATA, or to IDLE with a frame_done pulse if the latched length is 0.
REQ-020 SHALL, on a PID mismatch, update pid_id, pulse pid_err and go to IDLE.
REQ-021 SHALL seed the accumulator in PID with the PID byte if the mode is enhanced, otherwise with 0x00.
- Classic is forced when DIAG_CLASSIC=1 and id is 0x3C or 0x3D.
REQ-022 SHALL, in DATA, for each symbol:
- Output rx_byte=sym[8:1] with a rx_byte_valid pulse.
- Add the byte with end-around carry: acc = acc + byte, then add 1 if the 8-bit sum overflowed.
- Go to CHK after the latched length of bytes.
REQ-023 SHALL, in CHK, compare sym[8:1] with ~acc.
- Always pulse frame_done and go to IDLE.
- Also pulse chk_err on mismatch.
REQ-024 SHALL ignore sym_valid in IDLE; sym_valid is ignored in every other state only in the cycle where frame_start is high.
REQ-025 SHALL give frame_start priority over a simultaneous sym_valid.
REQ-026 SHALL pulse abort when frame_start arrives while the FSM is not in IDLE.
REQ-027 SHALL register all outputs; every pulse is exactly one cycle wide and appears the cycle after the triggering sym_valid or frame_start.
REQ-028 SHALL keep pid_id and rx_byte at their last values between pulses.

Reset
REQ-029 SHALL, while reset=0 at a clk edge, go to IDLE and clear all outputs, the counter, the accumulator and the latched config to 0.
REQ-030 SHALL let reset mid-frame discard the frame silently, with no abort, frame_done or error pulse.
REQ-031 SHALL ignore frame_start and sym_valid while reset=0.

Verification
REQ-032 SHALL cover a classic good frame:
- Stimulus: cfg_len=4, cfg_enh=0; PID sym 0x2A0 (byte 0x50, id 0x10); data 0x4A,0x55,0x93,0xE5; checksum 0xE6.
- Response: pid_ok, pid_id=0x10, 4 rx_byte_valid pulses, frame_done with no chk_err.
REQ-033 SHALL cover an enhanced good frame:
- Stimulus: same frame with cfg_enh=1 and checksum 0x96.
- Response: frame_done with no chk_err; checksum 0xE6 instead gives chk_err.
REQ-034 SHALL cover a parity error: PID byte 0x10 (sym 0x220) -> pid_err, pid_id=0x10, busy drops, and later data symbols are ignored.
REQ-035 SHALL cover the DIAG_CLASSIC override: id 0x3C (PID byte 0x3C), cfg_enh=1, data 8x0x00, checksum 0xFF -> frame_done with no chk_err.
REQ-036 SHALL cover framing and abort:
- Data symbol with sym[9]=0 -> frm_err, then IDLE.
- frame_start during DATA -> abort, then the new frame decodes normally.
REQ-037 SHALL cover boundaries:
- cfg_len=0 -> frame_done right after pid_ok.
- cfg_len=12 with MAX_LEN=8 -> exactly 8 data bytes, then checksum.
- reset=0 mid-DATA -> outputs 0 and no pulses.
